// File: rtl/ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// ex_muldiv_unit
//   Iterative RV32M multiply/divide unit for the EX stage. A request is
//   latched on accept. The unit then iterates one bit per cycle: shift-add
//   for multiply, restoring shift-subtract for divide. One FIX cycle applies
//   the sign and selects the result. The result is then held until it is
//   consumed. Divide-by-zero and signed overflow skip the iteration and
//   complete in one cycle.
//
// Ports
//   clk, rst        clock, asynchronous active-low reset
//   flush           synchronous kill of any in-flight or completed op
//   in_valid/ready  request handshake; in_funct3 selects the op
//   in_opa, in_opb  rs1 / rs2 values (XLEN)
//   in_tag          destination tag, returned unchanged on out_tag
//   out_valid/ready response handshake; out_result / out_tag payload
//   busy            high whenever the unit is not IDLE
//   dbg_state       current FSM state (IDLE=0, BUSY=1, FIX=2, DONE=3)
//
// Handshake: a transfer happens on a rising edge where valid & ready are
//   both high. The producer holds valid and the payload stable until that
//   edge. Ready never depends on valid on the same interface.
// ---------------------------------------------------------------------------
module ex_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_opa,
    input  logic [XLEN-1:0]  in_opb,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0]   ONE      = XLEN'(1);
    localparam logic [2*XLEN-1:0] ONE2     = (2*XLEN)'(1);
    localparam logic [XLEN-1:0]   MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [XLEN-1:0]     b_q, b_d;
    // Multiply: {partial product high, multiplier shifting out at bit 0}.
    // Divide:   {partial remainder, dividend shifting out / quotient in}.
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                neg_res_q, neg_res_d;
    logic                neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]     result_q, result_d;

    // ---------------- request decode ----------------
    logic            acc_is_div, a_signed, b_signed, neg_a, neg_b;
    logic [XLEN-1:0] mag_a, mag_b, fast_res;
    logic            div_zero, div_ovf, fast_path;

    always_comb begin
        acc_is_div = in_funct3[2];
        // MUL/MULH/MULHSU treat rs1 as signed; only MUL/MULH treat rs2 as signed.
        a_signed   = acc_is_div ? ~in_funct3[0] : (in_funct3[1:0] != 2'b11);
        b_signed   = acc_is_div ? ~in_funct3[0] : ~in_funct3[1];
        neg_a      = a_signed & in_opa[XLEN-1];
        neg_b      = b_signed & in_opb[XLEN-1];
        // The most-negative value maps to itself, which reads correctly as an unsigned magnitude.
        mag_a      = neg_a ? (~in_opa + ONE) : in_opa;
        mag_b      = neg_b ? (~in_opb + ONE) : in_opb;
        div_zero   = acc_is_div & (in_opb == '0);
        div_ovf    = acc_is_div & ~in_funct3[0] & (in_opa == MOST_NEG) & (in_opb == '1);
        fast_path  = div_zero | div_ovf;
        if (div_zero) begin
            fast_res = in_funct3[1] ? in_opa : '1;
        end else begin
            fast_res = in_funct3[1] ? '0 : in_opa;
        end
    end

    // ---------------- one iteration step ----------------
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift, div_diff;
    logic              div_ge;
    logic [XLEN-1:0]   div_rem;
    logic [2*XLEN-1:0] div_next;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, b_q};
        mul_next  = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_q};
        div_ge    = (div_shift >= {1'b0, b_q});
        div_rem   = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
        div_next  = {div_rem, acc_q[XLEN-2:0], div_ge};
    end

    // ---------------- sign fix and result select ----------------
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, fix_res;

    always_comb begin
        prod = neg_res_q ? (~acc_q + ONE2) : acc_q;
        quo  = neg_res_q ? (~acc_q[XLEN-1:0] + ONE) : acc_q[XLEN-1:0];
        rem  = neg_rem_q ? (~acc_q[2*XLEN-1:XLEN] + ONE) : acc_q[2*XLEN-1:XLEN];
        case (funct3_q)
            3'b000:                 fix_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = quo;
            default:                fix_res = rem;
        endcase
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d   = state_q;
        funct3_d  = funct3_q;
        tag_d     = tag_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;

        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        funct3_d  = in_funct3;
                        tag_d     = in_tag;
                        b_d       = mag_b;
                        acc_d     = {{XLEN{1'b0}}, mag_a};
                        cnt_d     = CNT_W'(XLEN - 1);
                        neg_res_d = neg_a ^ neg_b;
                        neg_rem_d = neg_a;
                        if (fast_path) begin
                            result_d = fast_res;
                            state_d  = S_DONE;
                        end else begin
                            state_d  = S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    acc_d = funct3_q[2] ? div_next : mul_next;
                    if (cnt_q == '0) begin
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_FIX: begin
                    result_d = fix_res;
                    state_d  = S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            funct3_q  <= '0;
            tag_q     <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            funct3_q  <= funct3_d;
            tag_q     <= tag_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign out_result = result_q;
    assign out_tag    = tag_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_ex_muldiv_unit
//   Directed bench for ex_muldiv_unit (XLEN=32, TAG_W=5). Expected values
//   are hand-computed constants. Latency is counted in negedges after the
//   accept edge, until out_valid is seen high.
// ---------------------------------------------------------------------------
module tb_ex_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_funct3;
    logic [31:0] in_opa;
    logic [31:0] in_opb;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        busy;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    ex_muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_funct3  (in_funct3),
        .in_opa     (in_opa),
        .in_opb     (in_opb),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Issues one request and waits for the result. With bp set, out_ready is
    // held low for 10 cycles once out_valid is up. The output must stay
    // stable during that time.
    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] t,
                          input logic [31:0] exp_res, input int exp_lat, input bit bp);
        int cyc;
        @(negedge clk);
        check({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        in_funct3 = f;
        in_opa    = a;
        in_opb    = b;
        in_tag    = t;
        out_ready = !bp;
        @(posedge clk);
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            in_valid = 1'b0;
            cyc++;
            if (out_valid) break;
        end
        check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({name, "_latency"}, cyc, exp_lat);
        check({name, "_result"}, out_result, exp_res);
        check({name, "_tag"}, {27'd0, out_tag}, {27'd0, t});
        check({name, "_state_done"}, {30'd0, dbg_state}, 32'd3);
        if (bp) begin
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                check({name, "_bp_valid"}, {31'd0, out_valid}, 32'd1);
                check({name, "_bp_result"}, out_result, exp_res);
                check({name, "_bp_tag"}, {27'd0, out_tag}, {27'd0, t});
                check({name, "_bp_in_ready"}, {31'd0, in_ready}, 32'd0);
            end
            out_ready = 1'b1;
        end
        @(negedge clk);
        check({name, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
        check({name, "_ready_back"}, {31'd0, in_ready}, 32'd1);
        check({name, "_busy_low"}, {31'd0, busy}, 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit saw_valid;
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_funct3 = 3'd0;
        in_opa    = 32'd0;
        in_opb    = 32'd0;
        in_tag    = 5'd0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_result", out_result, 32'd0);
        check("reset_tag", {27'd0, out_tag}, 32'd0);
        check("reset_state", {30'd0, dbg_state}, 32'd0);

        // Multiply family
        run_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 5'd3,  32'hFFFFFFEB, 34, 1'b0);
        run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'hFFFFFFFE, 34, 1'b0);
        run_op("mulh",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'h00000000, 34, 1'b0);
        run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFF, 34, 1'b0);

        // Divide family
        run_op("div",    3'b100, 32'hFFFFFFF9, 32'd2,        5'd5,  32'hFFFFFFFD, 34, 1'b0);
        run_op("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, 34, 1'b0);
        run_op("divu",   3'b101, 32'd100,      32'd7,        5'd7,  32'd14,       34, 1'b0);
        run_op("remu",   3'b111, 32'd100,      32'd7,        5'd8,  32'd2,        34, 1'b0);

        // Fast path
        run_op("div0",   3'b100, 32'd5,        32'd0,        5'd10, 32'hFFFFFFFF, 1, 1'b0);
        run_op("remu0",  3'b111, 32'd5,        32'd0,        5'd11, 32'd5,        1, 1'b0);
        run_op("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, 1, 1'b0);
        run_op("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'd0,        1, 1'b0);

        // Backpressure
        run_op("bp_divu", 3'b101, 32'd100,     32'd7,        5'd9,  32'd14,       34, 1'b1);

        // Flush in BUSY cycle 12 with a competing request
        @(negedge clk);
        in_valid  = 1'b1;
        in_funct3 = 3'b101;
        in_opa    = 32'd100;
        in_opb    = 32'd7;
        in_tag    = 5'd4;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (11) @(negedge clk);
        check("flush_pre_busy", {31'd0, busy}, 32'd1);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_funct3 = 3'b000;
        in_opa    = 32'd3;
        in_opb    = 32'd3;
        in_tag    = 5'd7;
        @(posedge clk);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_state", {30'd0, dbg_state}, 32'd0);
        saw_valid = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        check("flush_no_result", {31'd0, saw_valid}, 32'd0);
        check("flush_idle_after", {31'd0, in_ready}, 32'd1);

        // Asynchronous reset mid-operation
        @(negedge clk);
        in_valid  = 1'b1;
        in_funct3 = 3'b000;
        in_opa    = 32'd7;
        in_opb    = 32'd3;
        in_tag    = 5'd21;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("prerst_busy", {31'd0, busy}, 32'd1);
        check("prerst_tag", {27'd0, out_tag}, 32'd21);
        #2;
        rst = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_result", out_result, 32'd0);
        check("rst_tag", {27'd0, out_tag}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        saw_valid = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        check("rst_no_result", {31'd0, saw_valid}, 32'd0);

        // A plain op still works after reset
        run_op("post_rst_mul", 3'b000, 32'd6, 32'd9, 5'd30, 32'd54, 34, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
